// File: rtl/l2_mem_pkg.sv
// Shared constants, FSM state encoding and address helpers for the L2 backing memory.
// The localparams describe the default configuration; modules derive their own from parameters.
package l2_mem_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned OFFSET_BITS    = $clog2(BYTES_PER_WORD);
    localparam int unsigned LINE_BITS      = 2;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t RD_WAIT  = 3'd1;
    localparam state_t RD_BURST = 3'd2;
    localparam state_t WR_BURST = 3'd3;
    localparam state_t WR_WAIT  = 3'd4;

    // Byte address -> word index, wrapped into a power-of-2 deep array.
    function automatic logic [31:0] word_index(input logic [63:0] byte_addr,
                                               input int unsigned offset_bits,
                                               input int unsigned depth_words);
        logic [63:0] idx;
        idx = byte_addr >> offset_bits;
        return idx[31:0] & (depth_words - 1);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] word_idx,
                                              input int unsigned line_words);
        return word_idx & ~(line_words - 1);
    endfunction

endpackage

// File: rtl/l2_backing_mem_if.sv
// Request / write-beat / read-beat bus between the L2 cache (master) and its backing memory (slave).
interface l2_backing_mem_if
    import l2_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8 * BYTES_PER_WORD,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    l2_req_valid;
    logic                    l2_req_ready;
    logic                    l2_req_write;
    logic [ADDR_WIDTH-1:0]   l2_req_addr;
    logic [DATA_WIDTH-1:0]   l2_wdata;
    logic [DATA_WIDTH/8-1:0] l2_wstrb;
    logic                    l2_wdata_valid;
    logic                    l2_wdata_ready;
    logic                    l2_wr_done;
    logic [DATA_WIDTH-1:0]   l2_rdata;
    logic                    l2_rdata_valid;
    logic                    l2_rdata_last;
    logic                    l2_rdata_ready;

    modport master (
        output l2_req_valid, l2_req_write, l2_req_addr,
        output l2_wdata, l2_wstrb, l2_wdata_valid, l2_rdata_ready,
        input  l2_req_ready, l2_wdata_ready, l2_wr_done,
        input  l2_rdata, l2_rdata_valid, l2_rdata_last
    );

    modport slave (
        input  l2_req_valid, l2_req_write, l2_req_addr,
        input  l2_wdata, l2_wstrb, l2_wdata_valid, l2_rdata_ready,
        output l2_req_ready, l2_wdata_ready, l2_wr_done,
        output l2_rdata, l2_rdata_valid, l2_rdata_last
    );
endinterface

// File: rtl/l2_mem_array.sv
// Single-port word array with byte-enable writes and a registered (1-cycle) read port.
module l2_mem_array #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           we,
    input  logic [DATA_WIDTH/8-1:0]        be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH-1:0]          rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // NOTE: the storage has no reset branch so it maps onto block RAM; contents survive rst.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Output register holds its beat until the next read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/l2_backing_mem.sv
// Line-burst backing memory for the L2: serialised read/write bursts with programmable latency.
module l2_backing_mem
    import l2_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8 * BYTES_PER_WORD,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LINE_WORDS  = 2 ** LINE_BITS,
    parameter int unsigned RD_LATENCY  = 8,
    parameter int unsigned WR_LATENCY  = 4
) (
    input logic             clk,
    input logic             rst,
    l2_backing_mem_if.slave bus
);
    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned WORD_OFFSET = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_BITS    = $clog2(DEPTH_WORDS);
    localparam int unsigned BEAT_BITS   = $clog2(LINE_WORDS);
    localparam int unsigned MAX_LAT     = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_BITS    = $clog2(MAX_LAT) + 1;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT   = BEAT_BITS'(LINE_WORDS - 1);
    localparam logic [CNT_BITS-1:0]  RD_WAIT_END = CNT_BITS'(RD_LATENCY - 1);
    localparam logic [CNT_BITS-1:0]  WR_WAIT_END = CNT_BITS'(WR_LATENCY - 2);

    if (DATA_WIDTH == 0 || DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line
        $error("LINE_WORDS must be a power of 2 and at least 2");
    end
    if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || DEPTH_WORDS % LINE_WORDS != 0) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of 2 and a multiple of LINE_WORDS");
    end
    if (RD_LATENCY < 1 || WR_LATENCY < 1) begin : g_bad_latency
        $error("RD_LATENCY and WR_LATENCY must be at least 1");
    end

    state_t                state_q;
    logic [IDX_BITS-1:0]   base_q;
    logic [BEAT_BITS-1:0]  beat_q;
    logic [CNT_BITS-1:0]   lat_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic                  wr_done_q;

    logic [IDX_BITS-1:0]   req_base;
    logic [BEAT_BITS-1:0]  beat_inc;
    logic                  wr_beat;
    logic                  rd_first;
    logic                  rd_hs;
    logic                  rd_next;
    logic                  mem_en;
    logic                  mem_we;
    logic [IDX_BITS-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign req_base = IDX_BITS'(line_base(word_index(64'(bus.l2_req_addr), WORD_OFFSET, DEPTH_WORDS),
                                          LINE_WORDS));
    assign beat_inc = beat_q + 1'b1;
    assign wr_beat  = (state_q == WR_BURST) && bus.l2_wdata_valid;
    // The first read is issued in the last wait cycle so beat 0 appears exactly RD_LATENCY+1 after accept.
    assign rd_first = (state_q == RD_WAIT) && (lat_q == RD_WAIT_END);
    assign rd_hs    = (state_q == RD_BURST) && rvalid_q && bus.l2_rdata_ready;
    assign rd_next  = rd_hs && !rlast_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = base_q;
        if (!rst) begin
            if (wr_beat) begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = base_q | IDX_BITS'(beat_q);
            end else if (rd_first) begin
                mem_en = 1'b1;
            end else if (rd_next) begin
                mem_en   = 1'b1;
                mem_addr = base_q | IDX_BITS'(beat_inc);
            end
        end
    end

    l2_mem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en),
        .we    (mem_we),
        .be    (bus.l2_wstrb),
        .addr  (mem_addr),
        .wdata (bus.l2_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.l2_req_valid) begin
                        base_q  <= req_base;
                        beat_q  <= '0;
                        lat_q   <= '0;
                        state_q <= bus.l2_req_write ? WR_BURST : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_first) begin
                        state_q  <= RD_BURST;
                        rvalid_q <= 1'b1;
                        rlast_q  <= 1'b0;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                RD_BURST: begin
                    if (rd_hs) begin
                        if (rlast_q) begin
                            state_q  <= IDLE;
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            beat_q   <= '0;
                        end else begin
                            beat_q  <= beat_inc;
                            rlast_q <= (beat_inc == LAST_BEAT);
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_beat) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q <= '0;
                            lat_q  <= '0;
                            // A one-cycle write latency skips the wait state entirely.
                            if (WR_LATENCY == 1) begin
                                state_q   <= IDLE;
                                wr_done_q <= 1'b1;
                            end else begin
                                state_q <= WR_WAIT;
                            end
                        end else begin
                            beat_q <= beat_inc;
                        end
                    end
                end
                WR_WAIT: begin
                    if (lat_q == WR_WAIT_END) begin
                        state_q   <= IDLE;
                        wr_done_q <= 1'b1;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.l2_req_ready   = (state_q == IDLE);
    assign bus.l2_wdata_ready = (state_q == WR_BURST);
    assign bus.l2_wr_done     = wr_done_q;
    assign bus.l2_rdata       = mem_rdata;
    assign bus.l2_rdata_valid = rvalid_q;
    assign bus.l2_rdata_last  = rlast_q;
endmodule
